// File: rtl/intersection_scheduler.sv
// intersection_scheduler: six-phase two-road signal sequencer.
// NS is the main road and rests in green; EW is served on latched demand.
// All state advances on the falling edge of CLK; RES clears asynchronously.
module intersection_scheduler #(
   parameter int CW        = 8,
   parameter int MIN_GREEN = 8,
   parameter int EW_GREEN  = 6,
   parameter int YELLOW    = 3,
   parameter int ALLRED    = 1
) (
   input  logic       CLK,
   input  logic       RES,
   input  logic       TICK,
   input  logic       CAR_EW,
   input  logic       PED_REQ,
   input  logic       EMG,
   output logic [1:0] LIGHT_NS,
   output logic [1:0] LIGHT_EW,
   output logic       WALK,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR1  = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR2  = 3'd5
   } phase_t;

   localparam logic [1:0] RED = 2'b00, GRN = 2'b01, YLW = 2'b10;

   // Last-tick values: a phase of D ticks ends when the timer shows D-1.
   localparam logic [CW-1:0] MG_L = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] EG_L = CW'(EW_GREEN - 1);
   localparam logic [CW-1:0] YL_L = CW'(YELLOW - 1);
   localparam logic [CW-1:0] AR_L = CW'(ALLRED - 1);

   phase_t          state, nxt;
   logic [CW-1:0]   timer;
   logic            car_lat, ped_lat, ped_svc;
   logic            ew_entry, svc_n;
   logic [1:0]      ns_n, ew_n;

   assign STATE = state;

   // Next-phase decision from the current phase, timer and demand.
   always_comb begin
      nxt = state;
      case (state)
         NS_G: if (TICK && timer == MG_L && (car_lat || ped_lat) && !EMG) nxt = NS_Y;
         NS_Y: if (TICK && timer == YL_L) nxt = AR1;
         AR1:  if (TICK && timer == AR_L) nxt = EMG ? NS_G : EW_G;
         EW_G: if (EMG || (TICK && timer == EG_L)) nxt = EW_Y;
         EW_Y: if (TICK && timer == YL_L) nxt = AR2;
         AR2:  if (TICK && timer == AR_L) nxt = NS_G;
         default: nxt = AR2;
      endcase
   end

   // Light codes and walk service for the phase being entered, so outputs register with STATE.
   always_comb begin
      ns_n     = RED;
      ew_n     = RED;
      ew_entry = (nxt == EW_G) && (state != EW_G);
      svc_n    = ew_entry ? ped_lat : ped_svc;
      case (nxt)
         NS_G:    ns_n = GRN;
         NS_Y:    ns_n = YLW;
         EW_G:    ew_n = GRN;
         EW_Y:    ew_n = YLW;
         default: ;
      endcase
   end

   // Phase register, phase timer, demand latches and registered outputs.
   always_ff @(negedge CLK or posedge RES) begin
      if (RES) begin
         state    <= AR2;
         timer    <= '0;
         car_lat  <= 1'b0;
         ped_lat  <= 1'b0;
         ped_svc  <= 1'b0;
         LIGHT_NS <= RED;
         LIGHT_EW <= RED;
         WALK     <= 1'b0;
      end else begin
         state <= nxt;
         // NS green timer parks at its last tick so demand can end it on any later tick.
         if (nxt != state)
            timer <= '0;
         else if (TICK && !(state == NS_G && timer == MG_L))
            timer <= timer + 1'b1;
         // A request on the EW_G entry edge survives the clear for the next cycle.
         car_lat  <= CAR_EW  | (car_lat & ~ew_entry);
         ped_lat  <= PED_REQ | (ped_lat & ~ew_entry);
         ped_svc  <= svc_n;
         LIGHT_NS <= ns_n;
         LIGHT_EW <= ew_n;
         WALK     <= (nxt == EW_G) && svc_n && !EMG;
      end
   end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed scenarios plus random traffic,
// with a queue scoreboard fed by a tick-counting reference model.
module tb_intersection_scheduler;
   localparam int MG = 4, EWG = 3, YEL = 2, AR = 1;

   logic CLK = 1'b0, RES = 1'b0, TICK = 1'b0, CAR_EW = 1'b0, PED_REQ = 1'b0, EMG = 1'b0;
   logic [1:0] LIGHT_NS, LIGHT_EW;
   logic       WALK;
   logic [2:0] STATE;

   intersection_scheduler #(.CW(8), .MIN_GREEN(MG), .EW_GREEN(EWG), .YELLOW(YEL), .ALLRED(AR)) dut (
      .CLK(CLK), .RES(RES), .TICK(TICK), .CAR_EW(CAR_EW), .PED_REQ(PED_REQ), .EMG(EMG),
      .LIGHT_NS(LIGHT_NS), .LIGHT_EW(LIGHT_EW), .WALK(WALK), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] ns;
      logic [1:0] ew;
      logic       walk;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: phase index, ticks spent in phase, pending demand.
   int dur [6] = '{MG, YEL, AR, EWG, YEL, AR};
   int ns_of[6] = '{1, 2, 0, 0, 0, 0};
   int ew_of[6] = '{0, 0, 0, 1, 2, 0};
   int mp = 5, mt = 0;
   bit mcar = 0, mped = 0, msvc = 0, mwalk = 0;

   function automatic exp_t m_exp();
      exp_t x;
      x.st = 3'(mp); x.ns = 2'(ns_of[mp]); x.ew = 2'(ew_of[mp]); x.walk = mwalk;
      return x;
   endfunction

   function automatic void m_reset();
      mp = 5; mt = 0; mcar = 0; mped = 0; msvc = 0; mwalk = 0;
   endfunction

   function automatic void m_step(bit tk, bit c, bit p, bit e);
      int  np = mp;
      bit  done = tk && (mt + 1 >= dur[mp]);
      case (mp)
         0: if (done && (mcar || mped) && !e) np = 1;
         2: if (done) np = e ? 0 : 3;
         3: if (e || done) np = 4;
         default: if (done) np = (mp + 1) % 6;
      endcase
      if (np == 3 && mp != 3) begin
         msvc = mped; mcar = c; mped = p;
      end else begin
         mcar = mcar | c; mped = mped | p;
      end
      if (np != mp) mt = 0;
      else if (tk && !(mp == 0 && mt == MG - 1)) mt++;
      mwalk = (np == 3) && msvc && !e;
      mp = np;
   endfunction

   // One clock with the given inputs; expectation queued for the coming falling edge.
   task automatic cyc(input bit tk, input bit c, input bit p, input bit e);
      @(posedge CLK);
      RES = 0; TICK = tk; CAR_EW = c; PED_REQ = p; EMG = e;
      m_step(tk, c, p, e);
      q.push_back(m_exp());
   endtask

   task automatic rcyc();
      @(posedge CLK);
      RES = 1; TICK = 1'($urandom); CAR_EW = 1'($urandom); PED_REQ = 1'($urandom); EMG = 0;
      m_reset();
      q.push_back(m_exp());
   endtask

   task automatic run_until(input int ph, input bit tk, input bit c, input bit p, input bit e);
      int i;
      for (i = 0; i < 100 && mp != ph; i++) cyc(tk, c, p, e);
      if (mp != ph) begin
         n_cmp++; n_bad++;
         $display("FAIL run_until: phase %0d not reached, model at %0d", ph, mp);
      end
   endtask

   // Monitor: every falling edge the outputs are compared with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("state", STATE, e.st);
            chk("light_ns", LIGHT_NS, e.ns);
            chk("light_ew", LIGHT_EW, e.ew);
            chk("walk", WALK, e.walk);
            chk("both_non_red", int'(LIGHT_NS != 0 && LIGHT_EW != 0), 0);
         end
      end
   end

   initial begin
      bit e_h;
      // 1. Reset and startup, then idle hold.
      #2 RES = 1;
      #1;
      chk("rst_state", STATE, 5);
      chk("rst_ns", LIGHT_NS, 0);
      chk("rst_ew", LIGHT_EW, 0);
      chk("rst_walk", WALK, 0);
      repeat (3) rcyc();
      repeat (22) cyc(1, 0, 0, 0);

      // 2. Car pulse early in NS green, then full EW cycle.
      cyc(1, 1, 0, 0);
      repeat (20) cyc(1, 0, 0, 0);

      // 3. Pedestrian pulse during NS yellow; walk on the following EW service.
      cyc(1, 1, 0, 0);
      run_until(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0);
      repeat (25) cyc(1, 0, 0, 0);

      // 4. Tick every third cycle with car held.
      for (int i = 0; i < 90; i++) cyc(i % 3 == 0, 1, 0, 0);

      // 5. Emergency raised in EW green with a walk in service.
      cyc(1, 0, 1, 0);
      run_until(3, 1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      repeat (15) cyc(1, 1, 0, 1);
      repeat (10) cyc(1, 0, 0, 0);

      // 6. Emergency at AR1 exit, then asynchronous reset mid-EW green.
      cyc(1, 1, 0, 0);
      run_until(2, 1, 0, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(1, 1, 1, 0);
      run_until(3, 1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      @(posedge CLK);
      TICK = 1; CAR_EW = 0; PED_REQ = 0; EMG = 0;
      #2 RES = 1;
      #1;
      chk("async_rst_state", STATE, 5);
      chk("async_rst_ns", LIGHT_NS, 0);
      chk("async_rst_ew", LIGHT_EW, 0);
      chk("async_rst_walk", WALK, 0);
      m_reset();
      q.push_back(m_exp());
      repeat (2) rcyc();

      // Random traffic with sticky emergency and rare resets.
      e_h = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 29) == 0) e_h = ~e_h;
         if ($urandom_range(0, 149) == 0) rcyc();
         else cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 11) == 0, e_h);
      end

      repeat (3) @(posedge CLK);
      if (q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
Sequences a two-road intersection: main road (NS) and side road (EW), each driving a 2-bit light code. The block runs a six-phase state machine with per-phase tick-based timers and latched side-road and pedestrian demand. It also provides an emergency override that forces and holds NS green. It sits above the per-light register stage and drives the light codes directly; timing counts TICK strobes from an external prescaler.

Parameters:
CW, 8, phase timer width in bits; every duration parameter must be less than 2^CW.
MIN_GREEN, 8, minimum NS green in ticks (must be 1 or more).
EW_GREEN, 6, fixed EW green in ticks (must be 1 or more).
YELLOW, 3, yellow duration in ticks for either road (must be 1 or more).
ALLRED, 1, all-red clearance in ticks (must be 1 or more).

Ports:
CLK  input  1  clock; all state updates on falling edge.
RES  input  1  asynchronous reset, active-high.
TICK  input  1  single-cycle timing strobe; timers advance only when TICK=1.
CAR_EW  input  1  side-road vehicle sensor; level, sampled every edge.
PED_REQ  input  1  pedestrian button; sampled every edge.
EMG  input  1  emergency override; level.
LIGHT_NS  output  2  NS light: 00 red, 01 green, 10 yellow; 11 is never driven.
LIGHT_EW  output  2  EW light; same encoding as LIGHT_NS.
WALK  output  1  pedestrian walk indication.
STATE  output  3  current phase code, for debug.

Behaviour:
- Phase codes: 0 NS_G, 1 NS_Y, 2 AR1, 3 EW_G, 4 EW_Y, 5 AR2. Codes 6 and 7 go to AR2 on the next edge.
- Lights per phase:
  - NS_G: NS=01, EW=00.
  - NS_Y: NS=10, EW=00.
  - EW_G: NS=00, EW=01.
  - EW_Y: NS=00, EW=10.
  - AR1 and AR2: both 00.
- While RES=1: STATE=AR2, timer=0, car_lat=0, ped_lat=0, LIGHT_NS=00, LIGHT_EW=00, WALK=0. Reset takes effect immediately, including mid-phase. On release, the sequence restarts from AR2.
- Timer:
  - Cleared to 0 on every phase change.
  - Increments on an edge with TICK=1.
  - A timed phase of duration D ends on the edge where TICK=1 and timer==D-1, so it lasts exactly D ticks.
  - In NS_G the timer saturates at MIN_GREEN-1.
- Transitions:
  - NS_Y to AR1, after YELLOW.
  - AR1 to EW_G, after ALLRED; goes to NS_G instead if EMG=1 on that edge.
  - EW_G to EW_Y, after EW_GREEN.
  - EW_Y to AR2, after YELLOW.
  - AR2 to NS_G, after ALLRED.
  - NS_G to NS_Y: on an edge with TICK=1, timer==MIN_GREEN-1, demand (car_lat OR ped_lat) = 1, and EMG=0. With no demand, NS_G holds indefinitely.
- Demand latches:
  - car_lat is set by CAR_EW=1; ped_lat is set by PED_REQ=1.
  - Both latches are cleared on the edge entering EW_G.
  - If a request is high on that same edge, set wins and the latch remains 1.
  - ped_svc is captured as ped_lat on entry to EW_G.
  - Latches are retained through EMG.
- WALK = 1 only in EW_G with ped_svc=1 and EMG=0. WALK is registered, updating on the same edge as STATE.
- Emergency override (EMG=1):
  - NS_G holds regardless of demand or timer.
  - EW_G moves to EW_Y on the next edge, independent of TICK.
  - Other phases run normally, with AR1 redirected to NS_G as above.
  - After EMG falls, normal rules resume; the NS_G timer continues from its current value.
- Invariant: at no time are both LIGHT_NS and LIGHT_EW non-red.

Test Plan:
1. Reset and startup. Parameters MIN_GREEN=4, YELLOW=2, ALLRED=1, EW_GREEN=3; TICK=1 every cycle; assert RES, then release. Required: lights 00/00 and STATE=5 during reset; first edge after release gives STATE=0, LIGHT_NS=01. With no demand, STATE stays 0 for 20 or more cycles.
2. Car demand, same parameters. Pulse CAR_EW on cycle 1 of NS_G. Required phase sequence and lengths:
   - NS_G lasts 4 cycles.
   - NS_Y, 2 cycles, NS=10.
   - AR1, 1 cycle.
   - EW_G, 3 cycles, EW=01, WALK=0.
   - EW_Y, 2 cycles.
   - AR2, 1 cycle.
   - Then NS_G, holding with no further demand.
3. Pedestrian request. Pulse PED_REQ during NS_Y. Required: current cycle completes; the next NS_G lasts 4 cycles, then moves to NS_Y. WALK=1 for exactly the 3 EW_G cycles of that service.
4. TICK gating. TICK every 3rd cycle, CAR_EW held high. Required:
   - NS_G lasts 12 cycles and NS_Y lasts 6.
   - car_lat re-sets on EW_G entry, so the following NS_G ends after MIN_GREEN again.
5. Emergency during EW_G. Raise EMG at the 2nd cycle of EW_G and hold it. Required:
   - EW_Y on the next edge; EW_Y and AR2 run at normal length; then NS_G.
   - NS_G holds while EMG=1 even with CAR_EW=1.
   - WALK drops on the edge EMG is seen.
   - After EMG falls, NS_Y follows within 1 tick once the timer has reached MIN_GREEN-1.
6. Emergency in AR1, then reset mid-phase.
   - With EMG=1 on the AR1 exit edge, STATE goes 2 to 0 (not 3).
   - Assert RES asynchronously mid-EW_G, between clock edges: outputs go 00/00 and WALK=0 immediately, without waiting for an edge.
